// File: rtl/onehot_mask_eval_if.sv
// Vector/result bus for onehot_mask_eval: input strobe and vector in, registered result out.
interface onehot_mask_eval_if #(
   parameter int unsigned N_IN = 8
);
   logic            in_valid;
   logic [N_IN-1:0] d_in;
   logic            out_valid;
   logic            out;
   logic            onehot_err;

   modport master (output in_valid, d_in, input out_valid, out, onehot_err);
   modport slave  (input in_valid, d_in, output out_valid, out, onehot_err);
endinterface

// File: rtl/onehot_mask_eval.sv
// Two-stage registered one-hot checker with programmable match mask, sticky error and match counter.
// Optional macro ONEHOT_MASK_EVAL_STRICT_ONEHOT_EN: non-one-hot vectors always report out=0.
module onehot_mask_eval #(
   parameter int unsigned     N_IN         = 8,
   parameter logic [N_IN-1:0] DEFAULT_MASK = N_IN'(8'b1001_1100),
   parameter int unsigned     CNT_W        = 16
) (
   input  logic                 clk_50M,
   input  logic                 reset_n,
   onehot_mask_eval_if.slave    bus,
   input  logic                 cfg_we,
   input  logic [N_IN-1:0]      cfg_mask,
   input  logic                 clr_sticky,
   output logic                 err_sticky,
   output logic [CNT_W-1:0]     match_cnt,
   output logic [N_IN-1:0]      mask_q
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic            valid_s1;
   logic [N_IN-1:0] d_s1;
   logic [N_IN-1:0] mask_s1;
   logic            onehot_s1;
   logic            onehot_c;
   logic            result_c;
   logic            hit_c;

   // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
   assign onehot_c = (bus.d_in != '0) && ((bus.d_in & (bus.d_in - N_IN'(1))) == '0);

`ifdef ONEHOT_MASK_EVAL_STRICT_ONEHOT_EN
   assign result_c = (|(d_s1 & mask_s1)) & onehot_s1;
`else
   assign result_c = |(d_s1 & mask_s1);
`endif

   assign hit_c = bus.out_valid & bus.out;

   // Mask register; stage 1 samples the pre-update value.
   always_ff @(posedge clk_50M or negedge reset_n) begin
      if (!reset_n) begin
         mask_q <= DEFAULT_MASK;
      end else if (cfg_we) begin
         mask_q <= cfg_mask;
      end
   end

   // Stage 1: capture vector, mask in force and one-hot flag.
   always_ff @(posedge clk_50M or negedge reset_n) begin
      if (!reset_n) begin
         valid_s1  <= 1'b0;
         d_s1      <= '0;
         mask_s1   <= '0;
         onehot_s1 <= 1'b0;
      end else begin
         valid_s1 <= bus.in_valid;
         if (bus.in_valid) begin
            d_s1      <= bus.d_in;
            mask_s1   <= mask_q;
            onehot_s1 <= onehot_c;
         end
      end
   end

   // Stage 2: result; out/onehot_err hold while no result is produced.
   always_ff @(posedge clk_50M or negedge reset_n) begin
      if (!reset_n) begin
         bus.out_valid  <= 1'b0;
         bus.out        <= 1'b0;
         bus.onehot_err <= 1'b0;
      end else begin
         bus.out_valid <= valid_s1;
         if (valid_s1) begin
            bus.out        <= result_c;
            bus.onehot_err <= ~onehot_s1;
         end
      end
   end

   // Sticky error: a new error outranks a clear in the same cycle.
   always_ff @(posedge clk_50M or negedge reset_n) begin
      if (!reset_n) begin
         err_sticky <= 1'b0;
      end else if (bus.out_valid && bus.onehot_err) begin
         err_sticky <= 1'b1;
      end else if (clr_sticky) begin
         err_sticky <= 1'b0;
      end
   end

   // Saturating match counter; clear with a concurrent hit yields 1.
   always_ff @(posedge clk_50M or negedge reset_n) begin
      if (!reset_n) begin
         match_cnt <= '0;
      end else if (clr_sticky) begin
         match_cnt <= hit_c ? CNT_W'(1) : '0;
      end else if (hit_c && (match_cnt != CNT_MAX)) begin
         match_cnt <= match_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_onehot_mask_eval.sv
// Randomised and directed checks of onehot_mask_eval against a queue-based reference model.
module tb_onehot_mask_eval;

   logic       clk_50M = 1'b0;
   logic       reset_n = 1'b0;
   logic       cfg_we = 1'b0;
   logic [7:0] cfg_mask = 8'h00;
   logic       clr_sticky = 1'b0;
   logic       err_sticky, err_sticky3;
   logic [15:0] match_cnt;
   logic [2:0]  match_cnt3;
   logic [7:0]  mask_q, mask_q3;

   onehot_mask_eval_if #(.N_IN(8)) bus ();
   onehot_mask_eval_if #(.N_IN(8)) bus3 ();

   onehot_mask_eval #(.N_IN(8), .DEFAULT_MASK(8'h9C), .CNT_W(16)) dut (
      .clk_50M(clk_50M), .reset_n(reset_n), .bus(bus), .cfg_we(cfg_we), .cfg_mask(cfg_mask),
      .clr_sticky(clr_sticky), .err_sticky(err_sticky), .match_cnt(match_cnt), .mask_q(mask_q));

   onehot_mask_eval #(.N_IN(8), .DEFAULT_MASK(8'h9C), .CNT_W(3)) dut_sat (
      .clk_50M(clk_50M), .reset_n(reset_n), .bus(bus3), .cfg_we(cfg_we), .cfg_mask(cfg_mask),
      .clr_sticky(clr_sticky), .err_sticky(err_sticky3), .match_cnt(match_cnt3), .mask_q(mask_q3));

   always #10 clk_50M = ~clk_50M;

   typedef struct { int due; bit o; bit e; } res_t;
   res_t pend[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_fail = 0;

   bit       exp_valid, exp_out, exp_err, exp_sticky;
   int       exp_cnt, exp_cnt3;
   logic [7:0] exp_mask;

   task automatic model_reset();
      pend.delete();
      exp_valid = 0; exp_out = 0; exp_err = 0; exp_sticky = 0;
      exp_cnt = 0; exp_cnt3 = 0; exp_mask = 8'h9C;
   endtask

   // Drive one cycle of stimulus, advance one edge, update the reference model.
   task automatic tick(input bit v, input logic [7:0] d, input bit we, input logic [7:0] m, input bit clr);
      bit hit, r_o, r_e;
      bus.in_valid = v;  bus.d_in = d;
      bus3.in_valid = v; bus3.d_in = d;
      cfg_we = we; cfg_mask = m; clr_sticky = clr;
      @(posedge clk_50M);
      cyc++;
      hit = exp_valid && exp_out;
      if (exp_valid && exp_err) exp_sticky = 1;
      else if (clr) exp_sticky = 0;
      if (clr) begin
         exp_cnt = hit ? 1 : 0;
         exp_cnt3 = hit ? 1 : 0;
      end else if (hit) begin
         if (exp_cnt < 65535) exp_cnt++;
         if (exp_cnt3 < 7) exp_cnt3++;
      end
      exp_valid = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
         exp_valid = 1; exp_out = pend[0].o; exp_err = pend[0].e;
         void'(pend.pop_front());
      end
      if (v) begin
         r_e = ($countones(d) != 1);
         r_o = ((d & exp_mask) != 8'h00);
`ifdef ONEHOT_MASK_EVAL_STRICT_ONEHOT_EN
         if (r_e) r_o = 0;
`endif
         pend.push_back('{cyc + 1, r_o, r_e});
      end
      if (we) exp_mask = m;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(0, 8'h00, 0, 8'h00, 0);
   endtask

   task automatic test_reset();
      bus.in_valid = 0; bus.d_in = 0; bus3.in_valid = 0; bus3.d_in = 0;
      reset_n = 0;
      model_reset();
      #25;
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      n_cmp++; if (bus.out !== 1'b0 || bus.onehot_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_err: got %b/%b want 0/0", bus.out, bus.onehot_err); end
      n_cmp++; if (err_sticky !== 1'b0 || match_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_sticky_cnt: got %b/%0d want 0/0", err_sticky, match_cnt); end
      n_cmp++; if (mask_q !== 8'h9C) begin n_fail++; $display("FAIL reset_mask: got %h want 9c", mask_q); end
      @(negedge clk_50M);
      reset_n = 1;
      #1;
   endtask

   task automatic test_default_sweep();
      logic [7:0] vec [8] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
      bit         want [8] = '{1, 0, 0, 1, 1, 1, 0, 0};
      for (int i = 0; i < 10; i++) begin
         if (i < 8) tick(1, vec[i], 0, 8'h00, 0);
         else tick(0, 8'h00, 0, 8'h00, 0);
         if (i >= 1 && i <= 8) begin
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.out !== want[i-1] || bus.onehot_err !== 1'b0 || bus.out !== exp_out) begin
               n_fail++;
               $display("FAIL sweep_%h: got v%b o%b e%b want v1 o%b e0", vec[i-1], bus.out_valid, bus.out, bus.onehot_err, want[i-1]);
            end
         end
      end
      n_cmp++; if (match_cnt !== 16'd4 || match_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL sweep_cnt: got %0d want 4", match_cnt); end
      n_cmp++; if (err_sticky !== 1'b0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL sweep_sticky: got %b/%b want 0/0", err_sticky, bus.out_valid); end
   endtask

   task automatic test_illegal();
      tick(1, 8'h00, 0, 8'h00, 0);
      tick(1, 8'h90, 0, 8'h00, 0);
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out !== 1'b0 || bus.onehot_err !== 1'b1) begin n_fail++; $display("FAIL zero_vec: got v%b o%b e%b want v1 o0 e1", bus.out_valid, bus.out, bus.onehot_err); end
      tick(0, 8'h00, 0, 8'h00, 0);
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out !== exp_out || bus.onehot_err !== 1'b1) begin n_fail++; $display("FAIL multi_hot: got v%b o%b e%b want v1 o%b e1", bus.out_valid, bus.out, bus.onehot_err, exp_out); end
      n_cmp++; if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL sticky_set: got %b want 1", err_sticky); end
      idle(2);
      n_cmp++; if (bus.out !== exp_out || bus.onehot_err !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL hold: got v%b o%b e%b want v0 o%b e1", bus.out_valid, bus.out, bus.onehot_err, exp_out); end
   endtask

   task automatic test_mask_change();
      tick(1, 8'h04, 1, 8'h01, 0);
      tick(1, 8'h04, 0, 8'h00, 0);
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out !== 1'b1) begin n_fail++; $display("FAIL mask_old: got v%b o%b want v1 o1", bus.out_valid, bus.out); end
      tick(0, 8'h00, 0, 8'h00, 0);
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out !== 1'b0) begin n_fail++; $display("FAIL mask_new: got v%b o%b want v1 o0", bus.out_valid, bus.out); end
      n_cmp++; if (mask_q !== 8'h01 || mask_q !== exp_mask) begin n_fail++; $display("FAIL mask_q: got %h want 01", mask_q); end
      idle(1);
   endtask

   task automatic test_clear_race();
      tick(1, 8'h00, 0, 8'h00, 0);
      tick(0, 8'h00, 0, 8'h00, 0);
      tick(0, 8'h00, 0, 8'h00, 1);
      n_cmp++; if (err_sticky !== 1'b1 || err_sticky !== exp_sticky) begin n_fail++; $display("FAIL clr_race: got %b want 1", err_sticky); end
      tick(0, 8'h00, 0, 8'h00, 1);
      n_cmp++; if (err_sticky !== 1'b0 || match_cnt !== 16'd0) begin n_fail++; $display("FAIL clr_plain: got %b/%0d want 0/0", err_sticky, match_cnt); end
      // Clear coinciding with a hit leaves the count at 1.
      tick(1, 8'h01, 0, 8'h00, 0);
      tick(0, 8'h00, 0, 8'h00, 0);
      tick(0, 8'h00, 0, 8'h00, 1);
      n_cmp++; if (match_cnt !== 16'd1 || match_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL clr_hit: got %0d want 1", match_cnt); end
   endtask

   task automatic test_saturation();
      tick(0, 8'h00, 1, 8'h9C, 1);
      for (int i = 0; i < 10; i++) tick(1, 8'h80, 0, 8'h00, 0);
      idle(3);
      n_cmp++; if (match_cnt3 !== 3'd7 || match_cnt3 !== 3'(exp_cnt3)) begin n_fail++; $display("FAIL sat_cnt3: got %0d want 7", match_cnt3); end
      n_cmp++; if (match_cnt !== 16'd10 || match_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL sat_cnt16: got %0d want 10", match_cnt); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         bit   v, we, clr;
         logic [7:0] d, m;
         v = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 3))
            0: d = 8'h00;
            1, 2: d = 8'h01 << $urandom_range(0, 7);
            default: d = 8'($urandom);
         endcase
         we = ($urandom_range(0, 15) == 0);
         m = 8'($urandom);
         clr = ($urandom_range(0, 19) == 0);
         tick(v, d, we, m, clr);
         n_cmp++; if (bus.out_valid !== exp_valid) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b want %b", i, bus.out_valid, exp_valid); end
         n_cmp++; if (bus.out !== exp_out || bus.onehot_err !== exp_err) begin n_fail++; $display("FAIL rnd_res@%0d: got o%b e%b want o%b e%b", i, bus.out, bus.onehot_err, exp_out, exp_err); end
         n_cmp++; if (err_sticky !== exp_sticky) begin n_fail++; $display("FAIL rnd_sticky@%0d: got %b want %b", i, err_sticky, exp_sticky); end
         n_cmp++; if (match_cnt !== 16'(exp_cnt) || match_cnt3 !== 3'(exp_cnt3)) begin n_fail++; $display("FAIL rnd_cnt@%0d: got %0d/%0d want %0d/%0d", i, match_cnt, match_cnt3, exp_cnt, exp_cnt3); end
         n_cmp++; if (mask_q !== exp_mask) begin n_fail++; $display("FAIL rnd_mask@%0d: got %h want %h", i, mask_q, exp_mask); end
      end
   endtask

   task automatic test_async_reset();
      tick(0, 8'h00, 1, 8'h11, 0);
      tick(1, 8'h10, 0, 8'h00, 0);
      tick(1, 8'h30, 0, 8'h00, 0);
      tick(1, 8'h01, 0, 8'h00, 0);
      tick(1, 8'h10, 0, 8'h00, 0);
      n_cmp++; if (err_sticky !== 1'b1 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset: got %b/%b want 1/1", err_sticky, bus.out_valid); end
      bus.in_valid = 1; bus.d_in = 8'h10; bus3.in_valid = 1; bus3.d_in = 8'h10;
      #5;
      reset_n = 0;
      model_reset();
      #1;
      n_cmp++; if (bus.out_valid !== 1'b0 || bus.out !== 1'b0 || bus.onehot_err !== 1'b0) begin n_fail++; $display("FAIL areset_out: got v%b o%b e%b want 0", bus.out_valid, bus.out, bus.onehot_err); end
      n_cmp++; if (err_sticky !== 1'b0 || match_cnt !== 16'd0 || mask_q !== 8'h9C) begin n_fail++; $display("FAIL areset_state: got %b/%0d/%h want 0/0/9c", err_sticky, match_cnt, mask_q); end
      bus.in_valid = 0; bus3.in_valid = 0;
      @(negedge clk_50M);
      reset_n = 1;
      for (int i = 0; i < 4; i++) begin
         tick(0, 8'h00, 0, 8'h00, 0);
         n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid@%0d: got %b want 0", i, bus.out_valid); end
      end
      tick(1, 8'h80, 0, 8'h00, 0);
      tick(0, 8'h00, 0, 8'h00, 0);
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out !== 1'b1) begin n_fail++; $display("FAIL resume_default: got v%b o%b want v1 o1", bus.out_valid, bus.out); end
   endtask

   initial begin
      test_reset();
      test_default_sweep();
      test_illegal();
      test_mask_change();
      test_clear_race();
      test_saturation();
      test_random();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
